hazard_detection_unit: RTL and testbench
========================================

Name: hazard_detection_unit

Overview:
- Decode-stage hazard controller for the 5-stage MIPS pipeline. It sits beside the forwarding unit and ahead of the IF/ID and ID/EX pipeline registers.
- Detects load-use hazards and branch-operand hazards that forwarding cannot cover. Branch operands can only be forwarded from EX/MEM to ID.
- Drives PC/IF_ID write-enables, the ID/EX control bubble and the IF/ID flush.
- A small FSM holds multi-cycle stalls. Counters record stall and flush events for performance checks.

Parameters:
- CNT_WIDTH, 32, width of the stall_count and flush_count counters (wrap at 2^CNT_WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous active-high reset
- ID_EX_MemRead  input  1  instruction in EX is a load
- ID_EX_RegWrite  input  1  instruction in EX writes a register
- ID_EX_RegisterDst  input  5  destination register of EX instruction, post RegDst mux
- EX_MEM_MemRead  input  1  instruction in MEM is a load
- EX_MEM_RegisterRd  input  5  destination register of MEM instruction
- IF_ID_RegisterRs  input  5  rs of instruction in ID
- IF_ID_RegisterRt  input  5  rt of instruction in ID
- beq  input  1  ID instruction is beq
- bne  input  1  ID instruction is bne
- jump  input  1  ID instruction is j/jal
- branch_taken  input  1  ID comparator result, already qualified by beq/bne
- PCWrite  output  1  PC load enable
- IF_ID_Write  output  1  IF/ID register load enable
- ID_EX_Bubble  output  1  zero all ID/EX control bits this cycle
- IF_ID_Flush  output  1  replace IF/ID contents with nop at next edge
- stall_count  output  CNT_WIDTH  total stalled cycles since reset
- flush_count  output  CNT_WIDTH  total flushes since reset

Behaviour:
- Register $0 never causes a hazard. Any match against register 0 is ignored.
- Define br = beq | bne. Define matchX(r) = (r != 0) && (r == IF_ID_RegisterRs || r == IF_ID_RegisterRt).
- H_LU (load-use, 1 stall) = ID_EX_MemRead && matchX(ID_EX_RegisterDst) && !br.
- H_BA (branch after ALU op, 1 stall) = br && ID_EX_RegWrite && !ID_EX_MemRead && matchX(ID_EX_RegisterDst).
- H_BL2 (branch after load in EX, 2 stalls) = br && ID_EX_MemRead && matchX(ID_EX_RegisterDst).
- H_BL1 (branch after load in MEM, 1 stall) = br && EX_MEM_MemRead && matchX(EX_MEM_RegisterRd).
- FSM has two states, RUN and HOLD1. Reset state is RUN.
- In RUN: stall = H_LU | H_BA | H_BL2 | H_BL1. Next state is HOLD1 if H_BL2, otherwise RUN.
- In HOLD1: stall = 1 unconditionally and hazard inputs are ignored. Next state is always RUN.
- stall = 1 forces PCWrite = 0, IF_ID_Write = 0 and ID_EX_Bubble = 1.
- stall = 0 gives PCWrite = 1, IF_ID_Write = 1 and ID_EX_Bubble = 0.
- IF_ID_Flush = !stall && ((br && branch_taken) || jump). Stall has priority: no flush while a branch is unresolved.
- All outputs are combinational from state and inputs, with zero-cycle latency.
- Counters:
  - stall_count increments by 1 on each edge where stall = 1.
  - flush_count increments by 1 on each edge where IF_ID_Flush = 1.
  - Both wrap modulo 2^CNT_WIDTH with no saturation.
- Reset:
  - While reset = 1: PCWrite = 1, IF_ID_Write = 1, ID_EX_Bubble = 0, IF_ID_Flush = 0, regardless of inputs.
  - At a reset edge: state = RUN, stall_count = 0, flush_count = 0.
  - Reset in HOLD1 abandons the remaining stall cycle.
  - Counters do not increment on a reset edge.
- Simultaneous hazards: if H_BL2 and H_BL1 both hold (both operands pending from different loads), H_BL2 governs. The result is 2 stall cycles total.

Test Plan:
1. Load-use hazard: lw $8 in EX (ID_EX_MemRead=1, Dst=8), add $9,$8,$8 in ID -> exactly 1 cycle with PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; stall_count 0->1; then RUN.
2. Branch after load: lw $8 in EX, beq $8,$0 in ID -> 2 consecutive stall cycles (RUN->HOLD1->RUN), stall_count=2. Then, with branch_taken=1 the next cycle, IF_ID_Flush=1 for one cycle and flush_count=1.
3. Branch after ALU op: add $5 in EX (RegWrite=1, MemRead=0), bne $5,$6 in ID -> 1 stall. In the same stall cycle with branch_taken=1, IF_ID_Flush=0.
4. $0 and no-match guards: lw $0 in EX with add using $0 gives no stall. lw $8 in EX with beq $9,$10 gives no stall. jump=1 with no hazard gives IF_ID_Flush=1 only.
5. Reset mid-stall: trigger H_BL2, assert reset during the HOLD1 cycle -> next cycle state=RUN, both counters=0, and PCWrite=1 while reset is high.
6. Counter wrap with CNT_WIDTH=4: 17 stall cycles -> stall_count=1.

Source files
------------

// File: rtl/hazard_detection_unit.sv
// rtl/hazard_detection_unit.sv - decode-stage load-use and branch-operand hazard controller
// Also drives the IF/ID flush and keeps the stall/flush event counters.
module hazard_detection_unit #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ID_EX_MemRead,
  input  logic                 ID_EX_RegWrite,
  input  logic [4:0]           ID_EX_RegisterDst,
  input  logic                 EX_MEM_MemRead,
  input  logic [4:0]           EX_MEM_RegisterRd,
  input  logic [4:0]           IF_ID_RegisterRs,
  input  logic [4:0]           IF_ID_RegisterRt,
  input  logic                 beq,
  input  logic                 bne,
  input  logic                 jump,
  input  logic                 branch_taken,
  output logic                 PCWrite,
  output logic                 IF_ID_Write,
  output logic                 ID_EX_Bubble,
  output logic                 IF_ID_Flush,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  typedef enum logic {RUN, HOLD1} state_t;

  state_t state;
  logic   br;
  logic   match_ex;
  logic   match_mem;
  logic   h_lu;
  logic   h_ba;
  logic   h_bl2;
  logic   h_bl1;
  logic   stall_core;
  logic   stall;
  logic   flush;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Register $0 is hardwired, so a producer targeting it never blocks the ID stage.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt);
    return (r != 5'd0) && ((r == rs) || (r == rt));
  endfunction

  always_comb begin
    br        = beq | bne;
    match_ex  = reg_match(ID_EX_RegisterDst, IF_ID_RegisterRs, IF_ID_RegisterRt);
    match_mem = reg_match(EX_MEM_RegisterRd, IF_ID_RegisterRs, IF_ID_RegisterRt);
    h_lu      = ID_EX_MemRead && match_ex && !br;
    h_ba      = br && ID_EX_RegWrite && !ID_EX_MemRead && match_ex;
    h_bl2     = br && ID_EX_MemRead && match_ex;
    h_bl1     = br && EX_MEM_MemRead && match_mem;
    stall_core = (state == HOLD1) || h_lu || h_ba || h_bl2 || h_bl1;
    // Reset masks everything so the pipeline free-runs while it is held.
    stall     = !reset && stall_core;
    flush     = !reset && !stall_core && ((br && branch_taken) || jump);
  end

  assign PCWrite      = !stall;
  assign IF_ID_Write  = !stall;
  assign ID_EX_Bubble = stall;
  assign IF_ID_Flush  = flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      // HOLD1 supplies the second stall cycle of a branch waiting on a load in EX.
      state <= (state == RUN && h_bl2) ? HOLD1 : RUN;
      if (stall) stall_count <= stall_count + CNT_ONE;
      if (flush) flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb/tb_hazard_detection_unit.sv - directed bench with per-cycle reference model
module tb_hazard_detection_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ID_EX_MemRead, ID_EX_RegWrite, EX_MEM_MemRead;
  logic [4:0]    ID_EX_RegisterDst, EX_MEM_RegisterRd, IF_ID_RegisterRs, IF_ID_RegisterRt;
  logic          beq, bne, jump, branch_taken;
  logic          PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush;
  logic [CW-1:0] stall_count, flush_count;

  int total = 0;
  int bad = 0;

  hazard_detection_unit #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_RegisterDst(ID_EX_RegisterDst), .EX_MEM_MemRead(EX_MEM_MemRead),
    .EX_MEM_RegisterRd(EX_MEM_RegisterRd), .IF_ID_RegisterRs(IF_ID_RegisterRs),
    .IF_ID_RegisterRt(IF_ID_RegisterRt), .beq(beq), .bne(bne), .jump(jump),
    .branch_taken(branch_taken), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .ID_EX_Bubble(ID_EX_Bubble), .IF_ID_Flush(IF_ID_Flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining forced stall cycles plus plain event tallies.
  int pending = 0;
  int m_stalls = 0;
  int m_flushes = 0;

  function automatic bit uses(input int r);
    return r != 0 && (r == int'(IF_ID_RegisterRs) || r == int'(IF_ID_RegisterRt));
  endfunction

  always @(negedge clk) begin
    bit is_br, want_stall, want_flush, two_cycle;
    is_br = beq || bne;
    two_cycle = is_br && ID_EX_MemRead && uses(ID_EX_RegisterDst);
    if (reset) begin
      want_stall = 0;
      want_flush = 0;
    end else if (pending > 0) begin
      want_stall = 1;
      want_flush = 0;
    end else begin
      want_stall = (ID_EX_MemRead && uses(ID_EX_RegisterDst) && !is_br)
                || (is_br && ID_EX_RegWrite && uses(ID_EX_RegisterDst))
                || two_cycle
                || (is_br && EX_MEM_MemRead && uses(EX_MEM_RegisterRd));
      want_flush = !want_stall && ((is_br && branch_taken) || jump);
    end
    check("pcwrite", PCWrite, !want_stall);
    check("ifid_write", IF_ID_Write, !want_stall);
    check("bubble", ID_EX_Bubble, want_stall);
    check("flush", IF_ID_Flush, want_flush);
    check("stall_count", stall_count, m_stalls % (1 << CW));
    check("flush_count", flush_count, m_flushes % (1 << CW));
    if (reset) begin
      pending = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (want_stall) m_stalls++;
      if (want_flush) m_flushes++;
      if (pending > 0) pending--;
      else if (two_cycle) pending = 1;
    end
  end

  task automatic idle();
    ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_RegisterDst = 0;
    EX_MEM_MemRead = 0; EX_MEM_RegisterRd = 0;
    IF_ID_RegisterRs = 0; IF_ID_RegisterRt = 0;
    beq = 0; bne = 0; jump = 0; branch_taken = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1;
    idle();
    #1;
    check("reset_pcwrite", PCWrite, 1);
    step(); step();
    check("reset_stall_count", stall_count, 0);
    reset = 0;

    // load-use: lw $8 in EX, add $9,$8,$8 in ID
    ID_EX_MemRead = 1; ID_EX_RegisterDst = 8; IF_ID_RegisterRs = 8; IF_ID_RegisterRt = 8;
    #1 check("lu_bubble", ID_EX_Bubble, 1);
    step(); idle();
    #1 check("lu_done", PCWrite, 1);
    check("lu_count", stall_count, 1);

    // branch after load in EX: two stalls then taken branch flushes
    ID_EX_MemRead = 1; ID_EX_RegisterDst = 8; beq = 1; IF_ID_RegisterRs = 8;
    step(); idle(); beq = 1; IF_ID_RegisterRs = 8; EX_MEM_MemRead = 1; EX_MEM_RegisterRd = 8;
    EX_MEM_MemRead = 0; EX_MEM_RegisterRd = 0; branch_taken = 1;
    #1 check("hold1_pcwrite", PCWrite, 0);
    check("hold1_no_flush", IF_ID_Flush, 0);
    step();
    #1 check("bl2_count", stall_count, 3);
    check("bl2_flush", IF_ID_Flush, 1);
    step(); idle();
    #1 check("bl2_flush_count", flush_count, 1);

    // branch after ALU op, taken in the stall cycle: no flush yet
    ID_EX_RegWrite = 1; ID_EX_RegisterDst = 5; bne = 1; IF_ID_RegisterRs = 5;
    IF_ID_RegisterRt = 6; branch_taken = 1;
    #1 check("ba_flush", IF_ID_Flush, 0);
    check("ba_stall", IF_ID_Write, 0);
    step(); ID_EX_RegWrite = 0; ID_EX_RegisterDst = 0;
    step(); idle();
    #1 check("ba_flush_count", flush_count, 2);

    // $0 and no-match guards, jump flush
    ID_EX_MemRead = 1;
    #1 check("zero_reg", PCWrite, 1);
    ID_EX_RegisterDst = 8; beq = 1; IF_ID_RegisterRs = 9; IF_ID_RegisterRt = 10;
    #1 check("nomatch", PCWrite, 1);
    step(); idle(); jump = 1;
    #1 check("jump_flush", IF_ID_Flush, 1);
    step(); idle();

    // two loads feeding a beq: BL2 governs, 2 stalls total
    ID_EX_MemRead = 1; ID_EX_RegisterDst = 8; EX_MEM_MemRead = 1; EX_MEM_RegisterRd = 9;
    beq = 1; IF_ID_RegisterRs = 8; IF_ID_RegisterRt = 9;
    step(); idle(); beq = 1; IF_ID_RegisterRs = 8; IF_ID_RegisterRt = 9;
    step(); idle();
    #1 check("bl2_bl1_count", stall_count, 6);
    check("jump_flush_count", flush_count, 3);

    // branch after load in MEM only: single stall
    EX_MEM_MemRead = 1; EX_MEM_RegisterRd = 7; bne = 1; IF_ID_RegisterRt = 7;
    step(); idle();
    #1 check("bl1_count", stall_count, 7);

    // reset during HOLD1
    ID_EX_MemRead = 1; ID_EX_RegisterDst = 8; beq = 1; IF_ID_RegisterRs = 8;
    step(); reset = 1;
    #1 check("reset_hold_pcwrite", PCWrite, 1);
    step(); reset = 0; idle(); beq = 1; IF_ID_RegisterRs = 8;
    #1 check("after_reset_run", PCWrite, 1);
    check("after_reset_stalls", stall_count, 0);
    check("after_reset_flushes", flush_count, 0);
    step(); idle();

    // 17 load-use stalls wrap a 4-bit counter to 1
    ID_EX_MemRead = 1; ID_EX_RegisterDst = 3; IF_ID_RegisterRt = 3;
    for (int i = 0; i < 17; i++) step();
    idle();
    #1 check("wrap_count", stall_count, 1);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
